// File: rtl/j_pit_bank.sv
// Programmable interval timer bank: NUM_CH prescaler+divider channels with
// one-shot/periodic mode, per-channel interrupt enable/pending and a merged irq.
module j_pit_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              cs,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] a,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    output logic              dout_oe,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam int CH_W = ADDR_W - 3;

    localparam logic [1:0] REG_PRE  = 2'd0;
    localparam logic [1:0] REG_DIV  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    logic [CH_W-1:0]  ch_sel;
    logic [1:0]       reg_sel;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] wval;
    logic             a_lsb_unused;

    assign ch_sel       = a[ADDR_W-1:3];
    assign reg_sel      = a[2:1];
    assign wr_en        = cs & we;
    assign rd_en        = cs & re;
    assign wval         = din[CNT_W-1:0];
    assign a_lsb_unused = a[0];

    logic [CNT_W-1:0]  pre_rld [NUM_CH];
    logic [CNT_W-1:0]  pre_cnt [NUM_CH];
    logic [CNT_W-1:0]  div_rld [NUM_CH];
    logic [CNT_W-1:0]  div_cnt [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] oneshot;
    logic [NUM_CH-1:0] ie;
    logic [NUM_CH-1:0] pending;

    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] wr_hit;
    logic [15:0]       rd_data;

    // Expiry is the tick on which both counters already sit at zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        expire = '0;
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            expire[i] = tick && en[i] && (pre_cnt[i] == '0) && (div_cnt[i] == '0);
            wr_hit[i] = wr_en && (int'(ch_sel) == i);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            // NOTE: these per-channel arrays are a handful of control flops, not a RAM, so they are reset.
            for (int i = 0; i < NUM_CH; i++) begin
                pre_rld[i] <= '0;
                pre_cnt[i] <= '0;
                div_rld[i] <= '0;
                div_cnt[i] <= '0;
            end
            en      <= '0;
            oneshot <= '0;
            ie      <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick && en[i]) begin
                    if (pre_cnt[i] != '0) begin
                        pre_cnt[i] <= pre_cnt[i] - CNT_W'(1);
                    end else begin
                        pre_cnt[i] <= pre_rld[i];
                        if (div_cnt[i] != '0)
                            div_cnt[i] <= div_cnt[i] - CNT_W'(1);
                        else
                            div_cnt[i] <= div_rld[i];
                    end
                end
                if (expire[i] && oneshot[i])
                    en[i] <= 1'b0;

                // NOTE: the last non-blocking assignment in the block wins, which sets collision priority:
                // CPU writes override the count update, and an expiry overrides a W1C of pending.
                if (wr_hit[i]) begin
                    case (reg_sel)
                        REG_PRE: begin
                            pre_rld[i] <= wval;
                            pre_cnt[i] <= wval;
                        end
                        REG_DIV: begin
                            div_rld[i] <= wval;
                            div_cnt[i] <= wval;
                        end
                        REG_CTRL: begin
                            en[i]      <= din[0];
                            oneshot[i] <= din[1];
                            ie[i]      <= din[2];
                        end
                        REG_STAT: begin
                            if (din[0])
                                pending[i] <= 1'b0;
                        end
                    endcase
                end
                if (expire[i])
                    pending[i] <= 1'b1;
            end
        end
    end

    // Out-of-range channel indices match no channel and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_sel) == i) begin
                case (reg_sel)
                    REG_PRE:  rd_data = 16'(pre_cnt[i]);
                    REG_DIV:  rd_data = 16'(div_cnt[i]);
                    REG_CTRL: rd_data = {13'b0, ie[i], oneshot[i], en[i]};
                    REG_STAT: rd_data = {15'b0, pending[i]};
                endcase
            end
        end
    end

    // Read data is sampled before this cycle's write lands, so we&re returns the old value.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            dout    <= '0;
            dout_oe <= 1'b0;
            irq     <= 1'b0;
            irq_vec <= '0;
        end else begin
            dout_oe <= rd_en;
            if (rd_en)
                dout <= rd_data;
            irq_vec <= pending & ie;
            irq     <= |(pending & ie);
        end
    end

endmodule

// File: tb/tb_j_pit_bank.sv
// Bench for j_pit_bank: directed scenarios plus random traffic, reads checked by a
// scoreboard fed from a linear-countdown reference model of each channel.
module tb_j_pit_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 6;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              tick;
    logic              cs;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] a;
    logic [15:0]       din;
    logic [15:0]       dout;
    logic              dout_oe;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    j_pit_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .tick    (tick),
        .cs      (cs),
        .we      (we),
        .re      (re),
        .a       (a),
        .din     (din),
        .dout    (dout),
        .dout_oe (dout_oe),
        .irq     (irq),
        .irq_vec (irq_vec)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: each channel is one countdown t = div*(pre_rld+1) + pre,
    // reaching zero then expiring on the next tick and restarting at period-1.
    longint unsigned   m_t  [NUM_CH];
    longint unsigned   m_pr [NUM_CH];
    longint unsigned   m_dr [NUM_CH];
    bit                m_en [NUM_CH];
    bit                m_os [NUM_CH];
    bit                m_ie [NUM_CH];
    bit                m_pend [NUM_CH];
    logic [NUM_CH-1:0] m_irqv;
    logic [15:0]       exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_t[i] = 0; m_pr[i] = 0; m_dr[i] = 0;
            m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
        end
        m_irqv = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic tk, input logic c, input logic w, input logic r,
                              input logic [ADDR_W-1:0] addr, input logic [15:0] d);
        int ch;
        int rs;
        logic [15:0] rv;
        logic [NUM_CH-1:0] pv;
        bit expd [NUM_CH];
        longint unsigned q;
        ch = int'(addr[ADDR_W-1:3]);
        rs = int'(addr[2:1]);
        if (c && r) begin
            rv = '0;
            if (ch < NUM_CH) begin
                case (rs)
                    0: rv = 16'(m_t[ch] % (m_pr[ch] + 1));
                    1: rv = 16'(m_t[ch] / (m_pr[ch] + 1));
                    2: rv = {13'b0, m_ie[ch], m_os[ch], m_en[ch]};
                    default: rv = {15'b0, m_pend[ch]};
                endcase
            end
            exp_q.push_back(rv);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            pv[i] = m_pend[i] & m_ie[i];
            expd[i] = 0;
            if (tk && m_en[i]) begin
                if (m_t[i] == 0) begin
                    expd[i] = 1;
                    m_t[i] = (m_pr[i] + 1) * (m_dr[i] + 1) - 1;
                    if (m_os[i]) m_en[i] = 0;
                end else begin
                    m_t[i] = m_t[i] - 1;
                end
            end
        end
        if (c && w && ch < NUM_CH) begin
            case (rs)
                0: begin
                    q = m_t[ch] / (m_pr[ch] + 1);
                    m_pr[ch] = longint'(d);
                    m_t[ch] = q * (m_pr[ch] + 1) + m_pr[ch];
                end
                1: begin
                    q = m_t[ch] % (m_pr[ch] + 1);
                    m_dr[ch] = longint'(d);
                    m_t[ch] = m_dr[ch] * (m_pr[ch] + 1) + q;
                end
                2: begin
                    m_en[ch] = d[0]; m_os[ch] = d[1]; m_ie[ch] = d[2];
                end
                default: if (d[0]) m_pend[ch] = 0;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++)
            if (expd[i]) m_pend[i] = 1;
        m_irqv = pv;
    endtask

    // One bus cycle: check registered irq outputs, drive inputs, advance the model.
    task automatic cyc(input logic tk, input logic c, input logic w, input logic r,
                       input logic [ADDR_W-1:0] addr, input logic [15:0] d);
        check("irq_vec", irq_vec, m_irqv);
        check("irq", irq, |m_irqv);
        tick = tk; cs = c; we = w; re = r; a = addr; din = d;
        model_step(tk, c, w, r, addr, d);
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int ch, input int r);
        logic [2:0] c3;
        logic [1:0] r2;
        c3 = 3'(ch);
        r2 = 2'(r);
        return {c3, r2, 1'b0};
    endfunction

    task automatic wr(input int ch, input int r, input logic [15:0] v, input logic tk);
        cyc(tk, 1'b1, 1'b1, 1'b0, addr_of(ch, r), v);
    endtask

    task automatic rd(input int ch, input int r, input logic tk);
        cyc(tk, 1'b1, 1'b0, 1'b1, addr_of(ch, r), 16'($urandom));
    endtask

    task automatic idle(input int n, input logic tk);
        repeat (n) cyc(tk, 1'b0, 1'b0, 1'b0, ADDR_W'($urandom), 16'($urandom));
    endtask

    // Run ticking cycles until the model says the next tick expires channel ch.
    task automatic wait_expiry(input int ch, input int max_cyc);
        int k;
        k = 0;
        while (!(m_en[ch] && m_t[ch] == 0) && k < max_cyc) begin
            idle(1, 1'b1);
            k++;
        end
        if (k == max_cyc) flag("wait_expiry");
    endtask

    // Read monitor: every dout_oe pulse consumes the oldest expected read.
    always @(negedge sys_clk) begin
        if (!reset && dout_oe) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_dout_oe");
            end else begin
                check("rd_data", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [15:0]       rv;
        int op;
        int rch;
        int rr;
        logic rtk;

        reset = 1'b1; tick = 1'b0; cs = 1'b0; we = 1'b0; re = 1'b0; a = '0; din = '0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("rst_dout", dout, 16'h0);
        check("rst_dout_oe", dout_oe, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_irq_vec", irq_vec, '0);
        reset = 1'b0;

        // Periodic channel 0: period 12, then W1C clears irq.
        wr(0, 0, 16'd2, 1'b0);
        wr(0, 1, 16'd3, 1'b0);
        wr(0, 2, 16'd5, 1'b0);
        idle(30, 1'b1);
        rd(0, 3, 1'b1);
        wr(0, 3, 16'd1, 1'b1);
        idle(3, 1'b1);
        wr(0, 2, 16'd0, 1'b0);
        wr(0, 3, 16'd1, 1'b0);

        // One-shot channel 1: expires after 5 ticks, en clears, counts frozen.
        wr(1, 0, 16'd0, 1'b0);
        wr(1, 1, 16'd4, 1'b0);
        wr(1, 2, 16'd7, 1'b0);
        idle(8, 1'b1);
        for (int r = 0; r < 4; r++) rd(1, (r + 2) % 4, 1'b1);
        wr(1, 3, 16'd1, 1'b0);

        // Tick gating at 25% duty with mid-run count reads.
        wr(0, 0, 16'd1, 1'b0);
        wr(0, 1, 16'd1, 1'b0);
        wr(0, 2, 16'd5, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 1) rd(0, (k / 4) % 2, 1'b0);
            else            cyc(k % 4 == 0, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        wr(0, 3, 16'd1, 1'b0);

        // Collisions on the expiry cycle: W1C, DIV write, CTRL clearing en.
        wr(0, 0, 16'd1, 1'b0);
        wr(0, 1, 16'd2, 1'b0);
        wait_expiry(0, 50);
        wr(0, 3, 16'd1, 1'b1);
        rd(0, 3, 1'b0);
        wait_expiry(0, 50);
        wr(0, 1, 16'd7, 1'b1);
        rd(0, 1, 1'b0);
        rd(0, 0, 1'b0);
        wait_expiry(0, 50);
        wr(0, 2, 16'd4, 1'b1);
        rd(0, 2, 1'b0);
        rd(0, 3, 1'b0);

        // Out-of-range channel 3: writes ignored, reads zero.
        wr(3, 0, 16'h1234, 1'b0);
        wr(3, 2, 16'h0007, 1'b0);
        for (int r = 0; r < 4; r++) rd(3, r, 1'b0);
        rd(0, 0, 1'b0);

        // Simultaneous write and read returns the pre-write value.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, addr_of(0, 1), 16'h0009);
        rd(0, 1, 1'b0);

        // Random traffic.
        repeat (2500) begin
            op  = int'($urandom_range(0, 9));
            rtk = ($urandom_range(0, 2) != 0);
            rch = int'($urandom_range(0, 3));
            rr  = int'($urandom_range(0, 3));
            ra  = addr_of(rch, rr) | ADDR_W'($urandom_range(0, 1));
            rv  = (rr < 2) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            if (op < 5)       cyc(rtk, 1'b0, 1'b0, 1'b0, ra, rv);
            else if (op < 7)  cyc(rtk, 1'b1, 1'b1, 1'b0, ra, rv);
            else if (op < 9)  cyc(rtk, 1'b1, 1'b0, 1'b1, ra, rv);
            else              cyc(rtk, 1'b1, 1'b1, 1'b1, ra, rv);
        end

        // Async reset while both channels run with pending set.
        wr(0, 0, 16'd0, 1'b0);
        wr(0, 1, 16'd1, 1'b0);
        wr(0, 2, 16'd5, 1'b0);
        wr(1, 0, 16'd1, 1'b0);
        wr(1, 1, 16'd0, 1'b0);
        wr(1, 2, 16'd5, 1'b0);
        idle(6, 1'b1);
        check("pre_rst_irq_vec", irq_vec, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("async_rst_irq", irq, 1'b0);
        check("async_rst_irq_vec", irq_vec, '0);
        check("async_rst_dout", dout, 16'h0);
        check("async_rst_dout_oe", dout_oe, 1'b0);
        model_reset();
        @(negedge sys_clk);
        reset = 1'b0;
        idle(10, 1'b1);
        rd(0, 0, 1'b1);
        rd(1, 2, 1'b1);
        rd(0, 3, 1'b1);
        wr(0, 2, 16'd5, 1'b0);
        idle(4, 1'b1);

        idle(3, 1'b0);
        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
